// File: rtl/digit_scan_sequencer_pkg.sv
// rtl/digit_scan_sequencer_pkg.sv - shared constants, digit index type and divider helpers
package digit_scan_sequencer_pkg;

  localparam int DIGIT_COUNT = 4;
  localparam int BCD_W       = 4;
  localparam int DIGITS_W    = DIGIT_COUNT * BCD_W;

  typedef logic [1:0] digit_idx_t;

  // Clock cycles spent on each digit slot.
  function automatic int calc_div(int clk_hz, int scan_hz);
    return clk_hz / scan_hz;
  endfunction

  // Pick one BCD nibble out of the packed four-digit word.
  function automatic logic [BCD_W-1:0] nibble_at(logic [DIGITS_W-1:0] word, digit_idx_t idx);
    return word[{idx, 2'b00} +: BCD_W];
  endfunction

endpackage

// File: rtl/digit_scan_sequencer_if.sv
// rtl/digit_scan_sequencer_if.sv - value/enable input and scan outputs of the digit scan sequencer
interface digit_scan_sequencer_if;
  import digit_scan_sequencer_pkg::*;

  logic                enable;
  logic [DIGITS_W-1:0] digits_in;
  digit_idx_t          digit_select;
  logic [BCD_W-1:0]    digit_value;
  logic                blank;
  logic                frame_tick;

  // Counter side: supplies the value and run control, observes the scan.
  modport master (
    output enable, digits_in,
    input  digit_select, digit_value, blank, frame_tick
  );

  // Sequencer side.
  modport slave (
    input  enable, digits_in,
    output digit_select, digit_value, blank, frame_tick
  );

endinterface

// File: rtl/digit_scan_sequencer_scan_prescaler.sv
// rtl/digit_scan_sequencer_scan_prescaler.sv - modulo-DIV counter with enable and terminal-count strobe
module digit_scan_sequencer_scan_prescaler #(
  parameter int DIV   = 10,
  parameter int CNT_W = $clog2(DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  assign tc = (count == LAST);

  // Advance while enabled, wrapping to zero after DIV-1; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (enable) begin
      count <= tc ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/digit_scan_sequencer.sv
// rtl/digit_scan_sequencer.sv - 4-digit display scan driver; LEADING_ZERO_BLANK_EN adds leading-zero suppression
module digit_scan_sequencer
  import digit_scan_sequencer_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 10_000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                   clk,
  input  logic                   rst_n,
  digit_scan_sequencer_if.slave  bus
);

  localparam int DIV   = calc_div(CLK_HZ, SCAN_HZ);
  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_next;
  logic                tc;
  digit_idx_t          sel_q;
  digit_idx_t          sel_next;
  logic [DIGITS_W-1:0] snap_q;
  logic [DIGITS_W-1:0] snap_next;
  logic                loaded_q;
  logic                wrap;
  logic                guard;
  logic                lz_blank;
  logic [BCD_W-1:0]    value_q;
  logic                blank_q;
  logic                tick_q;

  digit_scan_sequencer_scan_prescaler #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (bus.enable),
    .count  (count),
    .tc     (tc)
  );

  // Next-state view so every registered output lines up with the new slot.
  always_comb begin
    count_next = tc ? '0 : count + CNT_W'(1);
    sel_next   = tc ? sel_q + 2'd1 : sel_q;
    wrap       = tc && (sel_q == 2'd3);
    snap_next  = (wrap || !loaded_q) ? bus.digits_in : snap_q;
    guard      = int'(count_next) < GUARD_CYCLES;
`ifdef LEADING_ZERO_BLANK_EN
    case (sel_next)
      2'd1:    lz_blank = (snap_next[15:4]  == '0);
      2'd2:    lz_blank = (snap_next[15:8]  == '0);
      2'd3:    lz_blank = (snap_next[15:12] == '0);
      default: lz_blank = 1'b0;
    endcase
`else
    lz_blank = 1'b0;
`endif
  end

  // Digit rotation, per-frame snapshot and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= '0;
      snap_q   <= '0;
      loaded_q <= 1'b0;
      value_q  <= '0;
      blank_q  <= 1'b1;
      tick_q   <= 1'b0;
    end else if (bus.enable) begin
      sel_q    <= sel_next;
      snap_q   <= snap_next;
      loaded_q <= 1'b1;
      value_q  <= nibble_at(snap_next, sel_next);
      blank_q  <= guard || lz_blank;
      tick_q   <= wrap;
    end else begin
      blank_q  <= 1'b1;
      tick_q   <= 1'b0;
    end
  end

  assign bus.digit_select = sel_q;
  assign bus.digit_value  = value_q;
  assign bus.blank        = blank_q;
  assign bus.frame_tick   = tick_q;

endmodule

// File: tb/tb_digit_scan_sequencer.sv
// tb/tb_digit_scan_sequencer.sv - randomized self-checking bench for digit_scan_sequencer
module tb_digit_scan_sequencer;

  localparam int CLK_HZ  = 1000;
  localparam int SCAN_HZ = 100;
  localparam int GUARD   = 2;
  localparam int DIV     = CLK_HZ / SCAN_HZ;
  localparam int FRAME   = 4 * DIV;

  logic clk = 1'b0;
  logic rst_n;

  digit_scan_sequencer_if bus_if ();

  digit_scan_sequencer #(
    .CLK_HZ       (CLK_HZ),
    .SCAN_HZ      (SCAN_HZ),
    .GUARD_CYCLES (GUARD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: p = number of enabled edges since reset.
  int          p;
  logic [15:0] snap;
  int          exp_sel;
  int          exp_val;
  int          exp_blank;
  int          exp_tick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int lz_suppressed(input int sel, input logic [15:0] word);
`ifdef LEADING_ZERO_BLANK_EN
    return (sel != 0 && (word >> (4 * sel)) == 16'h0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    p         = 0;
    snap      = 16'h0000;
    exp_sel   = 0;
    exp_val   = 0;
    exp_blank = 1;
    exp_tick  = 0;
  endtask

  task automatic model_step(input logic en, input logic [15:0] din);
    exp_tick = 0;
    if (en) begin
      p++;
      if (p == 1 || p % FRAME == 0) snap = din;
      exp_tick = (p % FRAME == 0) ? 1 : 0;
    end
    exp_sel   = (p / DIV) % 4;
    exp_val   = int'((snap >> (4 * exp_sel)) & 16'hF);
    exp_blank = (!en || (p % DIV) < GUARD || lz_suppressed(exp_sel, snap) != 0) ? 1 : 0;
  endtask

  task automatic check_outputs();
    chk("digit_select", 32'(bus_if.digit_select), 32'(exp_sel));
    chk("digit_value",  32'(bus_if.digit_value),  32'(exp_val));
    chk("blank",        32'(bus_if.blank),        32'(exp_blank));
    chk("frame_tick",   32'(bus_if.frame_tick),   32'(exp_tick));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step(bus_if.enable, bus_if.digits_in);
    @(negedge clk);
    check_outputs();
  endtask

  // Asserted between edges: outputs must already be at reset values before any clock.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] w;
    int          k;
    w = 16'h0;
    for (int i = 0; i < 4; i++) w[4*i +: 4] = 4'($urandom_range(0, 9));
    k = $urandom_range(0, 4);
    for (int i = 4 - k; i < 4; i++) w[4*i +: 4] = 4'h0;
    return w;
  endfunction

  initial begin
    rst_n            = 1'b0;
    bus_if.enable    = 1'b0;
    bus_if.digits_in = 16'h0000;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Basic rotation, then a mid-frame value change while digit 1 is shown.
    bus_if.enable    = 1'b1;
    bus_if.digits_in = 16'h1234;
    repeat (52) cycle();
    bus_if.digits_in = 16'h5678;
    repeat (60) cycle();

    // Freeze at prescaler 5 of slot 2, then resume.
    for (int i = 0; i < FRAME && (p % FRAME) != 25; i++) cycle();
    bus_if.enable = 1'b0;
    repeat (20) cycle();
    bus_if.enable = 1'b1;
    repeat (12) cycle();

    // Reset in the middle of a frame.
    repeat (17) cycle();
    async_reset();

    // Leading-zero patterns.
    bus_if.digits_in = 16'h0042;
    repeat (90) cycle();
    bus_if.digits_in = 16'h0000;
    repeat (90) cycle();

    // Randomized run with value changes, enable drops and occasional resets.
    repeat (3000) begin
      cycle();
      if ($urandom_range(0, 7) == 0) bus_if.digits_in = rand_bcd();
      bus_if.enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 399) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
